// File: rtl/demux1x2_32_buf.sv
// Registered 1-to-2 demultiplexer with a one-entry holding register per
// output. Each output runs its own valid/ready handshake, so one consumer
// can stall while words keep flowing to the other.

// One output slot: a valid bit, a data register and a saturating
// delivery counter.
module demux1x2_32_buf_slot #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  dIn,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  data,
    output logic [CW-1:0] cnt
);

    logic deliver;

    assign deliver = valid & ready;

    // Valid bit: a load wins over a drain, so draining and loading on the
    // same edge keeps the slot full and gives one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          valid <= 1'b0;
        else if (load)    valid <= 1'b1;
        else if (deliver) valid <= 1'b0;
    end

    // Data register: only written on a load. After delivery it keeps its
    // last value instead of clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       data <= '0;
        else if (load) data <= dIn;
    end

    // Delivery counter: counts completed handshakes and sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         cnt <= '0;
        else if (deliver && cnt != '1)   cnt <= cnt + 1'b1;
    end

endmodule

// Top level: steers each accepted word to the slot chosen by S.
module demux1x2_32_buf #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  D,
    input  logic          S,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  F0,
    output logic          F0_valid,
    input  logic          F0_ready,
    output logic [W-1:0]  F1,
    output logic          F1_valid,
    input  logic          F1_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam int NUM_SLOTS = 2;

    logic [NUM_SLOTS-1:0]         slotValid;
    logic [NUM_SLOTS-1:0]         slotReady;
    logic [NUM_SLOTS-1:0]         slotLoad;
    logic [NUM_SLOTS-1:0][W-1:0]  slotData;
    logic [NUM_SLOTS-1:0][CW-1:0] slotCnt;
    logic                         accept;

    assign slotReady = {F1_ready, F0_ready};

    // Ready looks only at the currently selected slot, so a stalled slot
    // never blocks traffic steered to the other one. in_valid is left out
    // on purpose to avoid a valid->ready loop at the producer.
    assign in_ready = ~slotValid[S] | slotReady[S];
    assign accept   = in_valid & in_ready;
    assign slotLoad = {accept & S, accept & ~S};

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : gSlot
        demux1x2_32_buf_slot #(
            .W  (W),
            .CW (CW)
        ) uSlot (
            .clk   (clk),
            .rst   (rst),
            .load  (slotLoad[k]),
            .dIn   (D),
            .ready (slotReady[k]),
            .valid (slotValid[k]),
            .data  (slotData[k]),
            .cnt   (slotCnt[k])
        );
    end

    assign F0       = slotData[0];
    assign F1       = slotData[1];
    assign F0_valid = slotValid[0];
    assign F1_valid = slotValid[1];
    assign cnt0     = slotCnt[0];
    assign cnt1     = slotCnt[1];

endmodule

// File: doc/demux1x2_32_buf.md
Name: demux1x2_32_buf

Overview:
- Registered 32-bit 1-to-2 demultiplexer: the steering counterpart of the 32-bit 2:1 select path.
- Takes one 32-bit word per handshake on a single input and delivers it to output 0 or 1 according to select S.
- Each output has a one-entry holding register with its own valid/ready handshake, so the two consumers can stall independently.
- Used to route ALU/datapath results to one of two destination paths, e.g. write-back vs. store/forward.

Parameters:
- W, 32: data width of D, F0, F1.
- CW, 8: width of the per-output delivered-word counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- D  input  W  data word to be routed.
- S  input  1  destination select: 0 routes to F0, 1 routes to F1.
- in_valid  input  1  D and S are valid this cycle.
- in_ready  output  1  block accepts D this cycle (combinational).
- F0  output  W  output-0 data (registered).
- F0_valid  output  1  F0 holds an undelivered word.
- F0_ready  input  1  consumer 0 takes F0 this cycle.
- F1  output  W  output-1 data (registered).
- F1_valid  output  1  F1 holds an undelivered word.
- F1_ready  input  1  consumer 1 takes F1 this cycle.
- cnt0  output  CW  words delivered on output 0 (saturating).
- cnt1  output  CW  words delivered on output 1 (saturating).

Behaviour:
- Reset (async, rst=1): F0=F1=0, F0_valid=F1_valid=0, cnt0=cnt1=0. Effect is immediate, independent of clk.
- Reset mid-operation discards any held words; no output handshake completes while rst=1.
- Per-slot state: slot k (k=0,1) is a single valid bit Vk plus data register Fk.
- in_ready = ~V[S] | Fk_ready, where k=S. Purely combinational from S, the slot state and the consumer ready. It never depends on in_valid.
- Accept: accept = in_valid & in_ready. On the clock edge the slot selected by S loads D and sets its valid bit. The other slot is untouched.
- Latency: a word accepted at edge N is visible on Fk with Fk_valid=1 from edge N onward (one register stage). There is no combinational path from D to Fk.
- Delivery: handshake on slot k = Fk_valid & Fk_ready. Vk clears at the edge unless the same edge also accepts a new word into k.
- Simultaneous drain and load of the same slot: Vk stays 1 and Fk takes the new D. This gives full throughput of one word per cycle per slot.
- Stall: while Fk_valid=1 and Fk_ready=0, Fk is held stable and no word is accepted for slot k.
- Stall isolation: a stalled slot does not block words steered to the other slot. in_ready is evaluated against the currently presented S.
- Input side: D and S may change freely while accept=0. Nothing is committed before the accept edge.
- Fk after delivery: Fk keeps its last value while Vk=0. It is not cleared.
- Counters: cntk increments by 1 on each slot-k delivery handshake and saturates at 2^CW-1 (no wrap).
- Counters during reset: they do not count while rst=1.
- Concurrency: both slots may deliver in the same cycle, and both counters update independently.
- Ready tie-off: Fk_ready=1 while Fk_valid=0 has no effect.

Test Plan:
- Reset: assert rst with F0_valid=1 and cnt0=5 mid-operation -> F0=0, F0_valid=0, cnt0=0 immediately, before the next clk edge.
- Basic routing: D=32'hDEADBEEF, S=0, in_valid=1, both readys=1 -> one edge later F0=32'hDEADBEEF and F0_valid=1, F1_valid=0; the following edge gives cnt0=1.
- Back-to-back same slot: F0_ready held 1, words 1,2,3 on consecutive cycles with S=0 -> in_ready=1 every cycle; F0 shows 1,2,3 on consecutive cycles; cnt0=3.
- Stall isolation: F0 holds 32'h0000_00AA with F0_ready=0. Then S=0 with D=32'h11 gives in_ready=0 and F0 stays 32'hAA. Then S=1 with D=32'h22 gives in_ready=1, and F1=32'h22 one edge later.
- Drain+load same edge: F1_valid=1 with F1=32'h5, F1_ready=1, S=1, D=32'h6 -> after the edge F1=32'h6, F1_valid=1, cnt1 +1.
- Counter saturation: CW=4, 20 deliveries on output 1 -> cnt1 stops at 15 and cnt0 stays unaffected.
